// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell. The serial adder feeds it one bit pair per clock.
module FULL_ADDER (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  // Purely combinational sum and carry of three input bits.
  always_comb begin
    Sum  = Ain ^ Bin ^ Cin;
    Cout = (Ain & Bin) | (Ain & Cin) | (Bin & Cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are latched on Start, added LSB-first
// through a single FULL_ADDER cell, and the registered result is flagged with
// a one-cycle Done pulse.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow
// output Ovf.
//
// state | meaning
// IDLE  | waiting for Start; result outputs hold the last completed value
// RUN   | one operand bit pair added per cycle, WIDTH cycles in total
// DONE  | result just loaded; Done high for this single cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  FULL_ADDER u_fa (
    .Ain  (a_q[0]),
    .Bin  (b_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          a_d     = Ain;
          b_d     = Bin;
          carry_d = Cin;
          cnt_d   = '0;
          psum_d  = '0;
        end
      end
      RUN: begin
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = fa_sum;
        carry_d           = fa_cout;
        cnt_d             = cnt_q + CW'(1);
        if (last_bit) begin
          // Capture includes the bit produced in this final cycle.
          state_d = DONE;
          sum_d   = psum_d;
          cout_d  = fa_cout;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) begin
      ovf_d = carry_q ^ fa_cout;
    end
  end

  // Overflow flag register, held alongside Sum.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for the main
// scenarios and a 1-bit instance checked exhaustively. Expected results come
// from plain integer addition of the operands.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] ain, bin;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start1;
  logic [0:0]   a1, b1;
  logic         c1;
  logic         busy1, done1, cout1;
  logic [0:0]   sum1;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf, ovf1;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] last_exp_sum = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Ain(ain), .Bin(bin), .Cin(cin),
    .Busy(busy), .Done(done), .Sum(sum), .Cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .Ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .Clk(clk), .Rst(rst), .Start(start1), .Ain(a1), .Bin(b1), .Cin(c1),
    .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .Ovf(ovf1)
`endif
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return total[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
    int sa, sb, st;
    sa = int'($signed(a));
    sb = int'($signed(b));
    st = sa + sb + int'(c);
    return (st > 127) || (st < -128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
  endtask

  // Issue one operation and wait for its Done; lat counts edges from raising Start.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat, output int ndone, output logic held_ok);
    wait_idle();
    lat = 0; ndone = 0; held_ok = 1'b1;
    ain = a; bin = b; cin = c; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (busy) start = 1'b0;
      if (done) begin
        ndone++;
        break;
      end
      if (sum !== last_exp_sum) held_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
    int lat, nd;
    logic held;
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    run_op(a, b, c, lat, nd, held);
    vectors++;
    if (nd !== 1) begin
      miscompares++;
      $display("FAIL %s_done: got %0d done pulses, want 1", name, nd);
    end
    vectors++;
    if (lat !== W + 1) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, W + 1);
    end
    vectors++;
    if ({cout, sum} !== exp) begin
      miscompares++;
      $display("FAIL %s_result: a=%h b=%h c=%b got %h want %h", name, a, b, c, {cout, sum}, exp);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s_hold: Sum changed during RUN, want %h held", name, last_exp_sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if (ovf !== ref_ovf(a, b, c)) begin
      miscompares++;
      $display("FAIL %s_ovf: got %b want %b", name, ovf, ref_ovf(a, b, c));
    end
`endif
    last_exp_sum = exp[W-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    ain = '0; bin = '0; cin = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    tick(); tick();
    vectors++;
    if ({busy, done, cout, sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_w8: got busy/done/cout/sum=%b, want all 0", {busy, done, cout, sum});
    end
    vectors++;
    if ({busy1, done1, cout1, sum1} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_w1: got %b, want 0000", {busy1, done1, cout1, sum1});
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if ({ovf, ovf1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b want 00", {ovf, ovf1});
    end
`endif
    rst = 1'b0;
    last_exp_sum = '0;
    tick();
  endtask

  task automatic test_basic();
    check_op("basic", 8'h5A, 8'h33, 1'b0);
    vectors++;
    if (sum !== 8'h8D) begin
      miscompares++;
      $display("FAIL basic_const: got %h want 8d", sum);
    end
  endtask

  task automatic test_ripple();
    check_op("ripple_b1", 8'hFF, 8'h01, 1'b0);
    check_op("ripple_cin", 8'hFF, 8'h00, 1'b1);
  endtask

  task automatic test_start_while_busy();
    int nd;
    logic held;
    logic [W-1:0] got;
    logic [W:0] exp;
    exp = ref_add(8'h5A, 8'h33, 1'b0);
    wait_idle();
    nd = 0; held = 1'b1; got = '0;
    ain = 8'h5A; bin = 8'h33; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= W + 8; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (i == 3) begin
        start = 1'b1; ain = 8'h01; bin = 8'h01;
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        nd++;
        got = sum;
      end else if (nd == 0 && sum !== last_exp_sum) begin
        held = 1'b0;
      end
    end
    vectors++;
    if (nd !== 1) begin
      miscompares++;
      $display("FAIL busy_start_pulses: got %0d want 1", nd);
    end
    vectors++;
    if (got !== exp[W-1:0]) begin
      miscompares++;
      $display("FAIL busy_start_result: got %h want %h", got, exp[W-1:0]);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL busy_start_hold: Sum changed during RUN, want %h", last_exp_sum);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_queued: got busy=%b want 0", busy);
    end
    last_exp_sum = exp[W-1:0];
  endtask

  task automatic test_reset_mid();
    int nd;
    wait_idle();
    ain = W'($urandom); bin = W'($urandom); cin = 1'($urandom); start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, done, cout, sum} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: got busy/done/cout/sum=%b, want 0", {busy, done, cout, sum});
    end
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done) nd++;
    end
    vectors++;
    if (nd !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_nodone: got %0d pulses want 0", nd);
    end
    last_exp_sum = '0;
    check_op("rst_mid_next", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[3], ob[3];
    logic oc[3];
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int idx, nd, cyc, last_done;
    logic prev_busy;
    for (int k = 0; k < 3; k++) begin
      oa[k] = W'($urandom); ob[k] = W'($urandom); oc[k] = 1'($urandom);
    end
    wait_idle();
    idx = 0; nd = 0; cyc = 0; last_done = 0; prev_busy = busy;
    ain = oa[0]; bin = ob[0]; cin = oc[0]; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (busy && !prev_busy) begin
        exp_q.push_back(ref_add(ain, bin, cin));
        idx++;
        if (idx < 3) begin
          ain = oa[idx]; bin = ob[idx]; cin = oc[idx];
        end
      end
      prev_busy = busy;
      if (done) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        vectors++;
        if ({cout, sum} !== e) begin
          miscompares++;
          $display("FAIL b2b_result%0d: got %h want %h", nd, {cout, sum}, e);
        end
        if (nd > 0) begin
          vectors++;
          if (cyc - last_done !== W + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing%0d: got %0d want %0d", nd, cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          last_exp_sum = e[W-1:0];
          break;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (nd !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d done pulses want 3", nd);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_width1();
    int lat;
    logic [1:0] exp;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 10 && busy1; i++) tick();
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); c1 = 1'(v);
      exp = 2'(int'(a1) + int'(b1) + int'(c1));
      start1 = 1'b1;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        lat++;
        if (busy1) start1 = 1'b0;
        if (done1) break;
      end
      start1 = 1'b0;
      vectors++;
      if (lat !== 2 || done1 !== 1'b1) begin
        miscompares++;
        $display("FAIL w1_latency%0d: got %0d done=%b want 2 done=1", v, lat, done1);
      end
      vectors++;
      if ({cout1, sum1} !== exp) begin
        miscompares++;
        $display("FAIL w1_result%0d: got %b want %b", v, {cout1, sum1}, exp);
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf1 !== ((a1 == b1) && (exp[0] != a1[0]))) begin
        miscompares++;
        $display("FAIL w1_ovf%0d: got %b", v, ovf1);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
